// File: rtl/search_and_add_pkg.sv
// Shared types for the search_and_add job scheduler.
package search_and_add_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} sched_state_t;

    typedef struct packed {
        logic [31:0] words;
        logic [63:0] offset;
    } job_t;

    localparam int unsigned BURST_BYTES = 256;

endpackage

// File: rtl/search_and_add_sched_rr_pick.sv
// First-set search over a request vector starting at a rotating pointer.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     gnt_valid
);
    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] idx;

    // Walk from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = 1'b0;
        idx       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                gnt_id    = idx;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/search_and_add_sched.sv
// Round-robin scheduler slicing requester jobs onto one search_and_add_ctrl engine.
module search_and_add_sched
    import search_and_add_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int SLICE_WORDS = 256,
    parameter int WORD_BYTES  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*32-1:0]      req_num_of_words,
    input  logic [N_REQ*64-1:0]      req_memory_offset,
    output logic [N_REQ-1:0]         req_done,
    input  logic                     axonerve_ready,
    output logic                     sa_kick,
    input  logic                     sa_busy,
    output logic [31:0]              sa_num_of_words,
    output logic [63:0]              sa_memory_offset,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);
    localparam int IW = $clog2(N_REQ);

    sched_state_t     state;
    job_t             slot_q [N_REQ];
    job_t             cur;
    logic [N_REQ-1:0] occupied;
    logic [N_REQ-1:0] pending;
    logic [IW-1:0]    rr_ptr, pick_id, next_ptr;
    logic             pick_vld;
    logic [31:0]      slice_w, left_w;
    logic [63:0]      next_off;
    logic             slice_end, zero_job;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req       (pending),
        .ptr       (rr_ptr),
        .gnt_id    (pick_id),
        .gnt_valid (pick_vld)
    );

    assign cur       = slot_q[grant_id];
    assign slice_w   = (cur.words > 32'(SLICE_WORDS)) ? 32'(SLICE_WORDS) : cur.words;
    assign left_w    = cur.words - sa_num_of_words;
    assign next_off  = cur.offset + 64'(sa_num_of_words) * 64'(WORD_BYTES);
    assign next_ptr  = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign slice_end = (state == WAIT_DONE) && !sa_busy;
    assign zero_job  = (state == ISSUE) && (cur.words == '0);
    assign req_ready = ~occupied;
    assign busy      = (|occupied) || (state != IDLE);

    // pending drops as soon as the job is finished so IDLE cannot re-pick it;
    // occupied (and so req_ready) follows one cycle later, on the done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupied <= '0;
            pending  <= '0;
            for (int i = 0; i < N_REQ; i++) slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && !occupied[i]) begin
                    occupied[i]      <= 1'b1;
                    pending[i]       <= 1'b1;
                    slot_q[i].words  <= req_num_of_words[32*i +: 32];
                    slot_q[i].offset <= req_memory_offset[64*i +: 64];
                end else if (req_done[i]) begin
                    occupied[i] <= 1'b0;
                end
            end
            if (slice_end) begin
                slot_q[grant_id].words  <= left_w;
                slot_q[grant_id].offset <= next_off;
                if (left_w == '0) pending[grant_id] <= 1'b0;
            end
            if (zero_job) pending[grant_id] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            grant_id         <= '0;
            rr_ptr           <= '0;
            sa_kick          <= 1'b0;
            sa_num_of_words  <= '0;
            sa_memory_offset <= '0;
            req_done         <= '0;
        end else begin
            sa_kick  <= 1'b0;
            req_done <= '0;
            case (state)
                IDLE: begin
                    if (axonerve_ready && pick_vld) begin
                        grant_id <= pick_id;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (zero_job) begin
                        req_done[grant_id] <= 1'b1;
                        rr_ptr             <= next_ptr;
                        state              <= IDLE;
                    end else begin
                        sa_kick          <= 1'b1;
                        sa_num_of_words  <= slice_w;
                        sa_memory_offset <= cur.offset;
                        state            <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (sa_busy) state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!sa_busy) begin
                        if (left_w == '0) req_done[grant_id] <= 1'b1;
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_search_and_add_sched.sv
// Scoreboard bench for search_and_add_sched with a simple busy-pulse engine model.
module tb_search_and_add_sched;

    typedef struct {
        logic [31:0] w;
        logic [63:0] off;
    } kick_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_num_of_words = '0;
    logic [255:0] req_memory_offset = '0;
    logic [3:0]   req_done;
    logic         ax_rdy = 1'b1;
    logic         sa_kick;
    logic         sa_busy;
    logic [31:0]  sa_num_of_words;
    logic [63:0]  sa_memory_offset;
    logic         busy;
    logic [1:0]   grant_id;

    // second instance with 16-word slices for the offset wrap case
    logic [1:0]   w_valid = '0;
    logic [1:0]   w_ready;
    logic [63:0]  w_words = '0;
    logic [127:0] w_off = '0;
    logic [1:0]   w_done;
    logic         w_kick;
    logic         w_sa_busy;
    logic [31:0]  w_num;
    logic [63:0]  w_moff;
    logic         w_busy;
    logic [0:0]   w_gid;

    int    n_chk = 0;
    int    n_bad = 0;
    int    eng_cnt, w_cnt;
    int    kick_cnt = 0;
    int    done_exp [4] = '{0, 0, 0, 0};
    kick_t exp_q [4][$];
    int    kick_log [$];
    int    done_log [$];
    kick_t w_log [$];

    always #5 clk = ~clk;

    search_and_add_sched #(.N_REQ(4), .SLICE_WORDS(256), .WORD_BYTES(16)) u_dut (
        .clk(clk), .reset(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_num_of_words(req_num_of_words), .req_memory_offset(req_memory_offset),
        .req_done(req_done), .axonerve_ready(ax_rdy), .sa_kick(sa_kick), .sa_busy(sa_busy),
        .sa_num_of_words(sa_num_of_words), .sa_memory_offset(sa_memory_offset),
        .busy(busy), .grant_id(grant_id)
    );

    search_and_add_sched #(.N_REQ(2), .SLICE_WORDS(16), .WORD_BYTES(16)) u_wrap (
        .clk(clk), .reset(rst_n), .req_valid(w_valid), .req_ready(w_ready),
        .req_num_of_words(w_words), .req_memory_offset(w_off),
        .req_done(w_done), .axonerve_ready(1'b1), .sa_kick(w_kick), .sa_busy(w_sa_busy),
        .sa_num_of_words(w_num), .sa_memory_offset(w_moff),
        .busy(w_busy), .grant_id(w_gid)
    );

    // engine models: busy rises the cycle after a kick and holds for a few cycles
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_busy <= 1'b0; eng_cnt <= 0;
        end else if (sa_kick) begin
            sa_busy <= 1'b1; eng_cnt <= 4;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end else if (eng_cnt == 1) begin
            eng_cnt <= 0; sa_busy <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_sa_busy <= 1'b0; w_cnt <= 0;
        end else if (w_kick) begin
            w_sa_busy <= 1'b1; w_cnt <= 3;
        end else if (w_cnt > 1) begin
            w_cnt <= w_cnt - 1;
        end else if (w_cnt == 1) begin
            w_cnt <= 0; w_sa_busy <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (sa_kick) begin
                kick_t e;
                kick_cnt++;
                kick_log.push_back(int'(grant_id));
                chk("kick_owed", 64'(exp_q[grant_id].size() > 0), 64'd1);
                if (exp_q[grant_id].size() > 0) begin
                    e = exp_q[grant_id].pop_front();
                    chk("kick_words", 64'(sa_num_of_words), 64'(e.w));
                    chk("kick_off", sa_memory_offset, e.off);
                end
            end
            for (int r = 0; r < 4; r++) begin
                if (req_done[r]) begin
                    done_log.push_back(r);
                    chk("done_drained", 64'(exp_q[r].size()), 64'd0);
                    chk("done_owed", 64'(done_exp[r] > 0), 64'd1);
                    if (done_exp[r] > 0) done_exp[r]--;
                end
            end
            if (w_kick) w_log.push_back('{w_num, w_moff});
        end
    end

    task automatic submit(input logic [3:0] m, input logic [31:0] w, input logic [63:0] off);
        logic [31:0] rem, s;
        logic [63:0] o;
        @(posedge clk); #1;
        for (int r = 0; r < 4; r++) begin
            if (m[r]) begin
                req_valid[r] = 1'b1;
                req_num_of_words[32*r +: 32]  = w;
                req_memory_offset[64*r +: 64] = off;
                done_exp[r]++;
                rem = w;
                o   = off;
                while (rem > 0) begin
                    s = (rem > 32'd256) ? 32'd256 : rem;
                    exp_q[r].push_back('{s, o});
                    rem = rem - s;
                    o   = o + 64'(s) * 64'd16;
                end
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
        chk(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int n, k0, d0;
        int fair_exp [4];
        fair_exp = '{0, 2, 0, 2};

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'hF);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_kick", 64'(sa_kick), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_words", 64'(sa_num_of_words), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // fairness: two requesters, same cycle, two slices each
        kick_log.delete(); done_log.delete();
        submit(4'b0101, 32'd512, 64'h0);
        wait_idle("fair_idle");
        chk("fair_n", 64'(kick_log.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < kick_log.size()) chk("fair_order", 64'(kick_log[i]), 64'(fair_exp[i]));
        chk("fair_done_n", 64'(done_log.size()), 64'd2);
        if (done_log.size() == 2) begin
            chk("fair_done0", 64'(done_log[0]), 64'd0);
            chk("fair_done1", 64'(done_log[1]), 64'd2);
        end

        // single job: latency and done/ready timing
        submit(4'b0001, 32'd40, 64'h1000);
        n = 0;
        do begin @(negedge clk); n++; end while (!sa_kick && n < 20);
        chk("kick_lat", 64'(n), 64'd3);
        n = 0;
        while (!sa_busy && n < 20) begin @(negedge clk); n++; end
        while (sa_busy && n < 40) begin @(negedge clk); n++; end
        chk("busy_fell", 64'(sa_busy), 64'd0);
        @(negedge clk);
        chk("done0_pulse", 64'(req_done[0]), 64'd1);
        chk("ready0_low", 64'(req_ready[0]), 64'd0);
        @(negedge clk);
        chk("done0_once", 64'(req_done[0]), 64'd0);
        chk("ready0_back", 64'(req_ready[0]), 64'd1);
        wait_idle("single_idle");

        // slicing: 600 words -> 256, 256, 88
        kick_log.delete();
        submit(4'b0001, 32'd600, 64'h0);
        wait_idle("slice_idle");
        chk("slice_n", 64'(kick_log.size()), 64'd3);

        // zero-word job completes without a kick
        k0 = kick_cnt;
        submit(4'b0010, 32'd0, 64'h4000);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_done[1] && n < 20);
        chk("zero_lat", 64'(n), 64'd3);
        wait_idle("zero_idle");
        chk("zero_nokick", 64'(kick_cnt), 64'(k0));

        // gating on axonerve_ready
        ax_rdy = 1'b0;
        k0 = kick_cnt;
        submit(4'b0100, 32'd40, 64'h5000);
        repeat (20) @(negedge clk);
        chk("gate_nokick", 64'(kick_cnt), 64'(k0));
        chk("gate_busy", 64'(busy), 64'd1);
        @(posedge clk); #1 ax_rdy = 1'b1;
        wait_idle("gate_idle");
        chk("gate_kick", 64'(kick_cnt), 64'(k0 + 1));

        // wrap on the 16-word-slice instance
        @(posedge clk); #1;
        w_valid = 2'b01;
        w_words[31:0] = 32'd32;
        w_off[63:0]   = 64'hFFFF_FFFF_FFFF_FF00;
        @(posedge clk); #1 w_valid = '0;
        n = 0;
        do begin @(negedge clk); n++; end while (!w_done[0] && n < 200);
        chk("wrap_done", 64'(w_done[0]), 64'd1);
        chk("wrap_n", 64'(w_log.size()), 64'd2);
        if (w_log.size() == 2) begin
            chk("wrap_w0", 64'(w_log[0].w), 64'd16);
            chk("wrap_o0", w_log[0].off, 64'hFFFF_FFFF_FFFF_FF00);
            chk("wrap_w1", 64'(w_log[1].w), 64'd16);
            chk("wrap_o1", w_log[1].off, 64'h0);
        end

        // reset while a slice is in flight
        submit(4'b1000, 32'd600, 64'h8000);
        n = 0;
        while (!sa_busy && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("mid_busy", 64'(sa_busy), 64'd1);
        rst_n = 1'b0;
        d0 = done_log.size();
        k0 = kick_cnt;
        for (int r = 0; r < 4; r++) begin exp_q[r].delete(); done_exp[r] = 0; end
        @(negedge clk);
        chk("mrst_ready", 64'(req_ready), 64'hF);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(req_done), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("mrst_nodone", 64'(done_log.size()), 64'(d0));
        chk("mrst_nokick", 64'(kick_cnt), 64'(k0));
        chk("mrst_idle", 64'(busy), 64'd0);

        n = 0;
        for (int r = 0; r < 4; r++) n += exp_q[r].size() + done_exp[r];
        chk("sb_empty", 64'(n), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
